l1_i_top: RTL and testbench
===========================

Name: l1_i_top

Overview:
- Read-only L1 instruction cache between the core fetch port and the L2.
- 2-way set-associative, 32 sets, 64-byte (512-bit) lines, per-set LRU replacement.
- Returns one 32-bit word per core read. Stalls the core on a miss and refills the whole line from L2 through a request/ready handshake.
- Flush invalidates the entire cache.

Parameters:
- TNUM, 21, core tag width (address[31:11]).
- INUM, 26-TNUM (5), core index width (address[10:6]); sets = 2**INUM.
- TNUM_2, 18, L2 tag width.
- INUM_2, 26-TNUM_2 (8), L2 index width.
- Line size is fixed at 512 bits and the offset at 6 bits. Both are not parameters.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- nrst, in, 1, synchronous active-low reset.
- tag_C_L1, in, TNUM, request tag.
- index_C_L1, in, INUM, request set index.
- offset, in, 6, byte offset; [5:2] selects the word, [1:0] are ignored.
- read_C_L1, in, 1, core read request (level, held until stall drops).
- flush, in, 1, one-cycle invalidate-all pulse.
- stall, out, 1, core must hold its request.
- read_data_L1_C, out, 32, fetched word.
- read_L1_L2, out, 1, refill request to L2.
- index_L1_L2, out, INUM_2, L2 index.
- tag_L1_L2, out, TNUM_2, L2 tag.
- ready_L2_L1, in, 1, L2 line valid this cycle.
- read_data_L2_L1, in, 512, refill line.

Behaviour:
- Storage per set and way: valid bit, TNUM-bit tag, 512-bit line. One LRU bit per set (points to the victim way).
- Reset (nrst=0 at a clk edge):
  - all valid bits and LRU bits are cleared;
  - FSM goes to IDLE;
  - stall=0, read_L1_L2=0, read_data_L1_C=0.
  - Reset overrides everything, including an in-flight refill.
- Hit: way w is a hit when valid[w] && tag[w]==tag_C_L1 at the set given by index_C_L1. Hit detection is combinational.
- FSM states:
  - IDLE:
    - read_C_L1 && hit: stall=0; read_data_L1_C = line[w][offset[5:2]*32 +: 32] in the same cycle (zero-wait hit); at the edge, LRU[set] is set to the other way.
    - read_C_L1 && !hit: stall=1 combinationally; next state is MISS.
    - No read: stall=0, read_data_L1_C=0.
  - MISS:
    - stall=1, read_L1_L2=1.
    - {tag_L1_L2, index_L1_L2} = {tag_C_L1, index_C_L1} (26-bit block address re-split as 18/8 bits).
    - On an edge with ready_L2_L1=1:
      - write read_data_L2_L1 into the victim way (the invalid way if any, way0 first; otherwise the LRU way);
      - set its valid bit and tag;
      - set LRU to the other way;
      - drop read_L1_L2 and return to IDLE.
    - The next cycle re-evaluates as a hit (stall low, data valid).
  - While not in MISS, read_L1_L2=0. The L2 address outputs always mirror the current request.
- Refill data is captured only in the cycle ready_L2_L1=1. ready_L2_L1 outside MISS is ignored.
- The core request inputs are stable while stall=1. A request change during MISS retargets the refill to the new address; this is legal but not required to be useful.
- Flush:
  - at the edge, clears all valid and LRU bits and forces IDLE;
  - aborts an in-flight refill (read_L1_L2 drops next cycle; a later ready is ignored).
  - flush and a hit in the same cycle: read data is still returned that cycle and the flush wins for state.
- Each index maps to exactly one set; no wrap-around concerns. Offsets 0x00..0x3C select words 0..15.

Decomposition:
- Package l1_i_pkg holds:
  - line/word/offset width constants;
  - state enum {IDLE, MISS};
  - derived sets = 2**INUM.
- Sub-module l1_i_way_array, instantiated twice (one per way):
  - tag, valid and data storage;
  - synchronous write, combinational read.
- Top holds the FSM, LRU and word select.

Test Plan:
- Cold fill way0: after reset, read 0x0000_0040 (tag 0, idx 1, off 0).
  - Required: stall=1 and read_L1_L2=1 with index_L1_L2=0x01, tag_L1_L2=0.
  - L2 ready with line D (word0=0x1111_1111): the next cycle has stall=0 and read_data=0x1111_1111.
- Fill way1: read 0x0000_0840 (tag 1, idx 1), refill with E.
  - Then reread 0x0000_0040 offset 0x3C: hit, zero stall, returns D[511:480].
  - Reread 0x0000_0848: returns E word2.
- LRU replace: after hits way0 then way1, read tag 2 idx 1 and refill F.
  - Way0 is evicted: tag 0 misses, tag 1 still hits.
- L2 latency: hold ready_L2_L1 low 12 cycles after a miss.
  - stall and read_L1_L2 stay high throughout; completion occurs only on the ready cycle.
- Flush: pulse flush for 1 cycle after the fills; reading any previously cached address misses (read_L1_L2=1).
  - A flush during MISS ends the request; a subsequent ready writes nothing.
- Reset mid-miss: drop nrst during MISS.
  - Next cycle: stall=0, read_L1_L2=0, all addresses miss afterwards.

Source files
------------

// File: rtl/l1_i_pkg.sv
// ============================================================================
// l1_i_pkg: shared widths, FSM states and set-count helper for the L1 I-cache. Rev 1.0
// ============================================================================
`default_nettype none

package l1_i_pkg;

    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 6;
    localparam int NWAYS  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    function automatic int num_sets(input int inum);
        return 2 ** inum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1_i_way_array.sv
// ============================================================================
// l1_i_way_array: one cache way (valid, tag, line), sync write / comb read. Rev 1.0
// ============================================================================
`default_nettype none

module l1_i_way_array
    import l1_i_pkg::*;
#(
    parameter int TNUM = 21,
    parameter int INUM = 5
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic [INUM-1:0]   index,
    input  logic              we,
    input  logic [TNUM-1:0]   wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    output logic              valid,
    output logic [TNUM-1:0]   tag,
    output logic [LINE_W-1:0] line
);

    localparam int SETS = num_sets(INUM);

    logic [SETS-1:0]   valid_q;
    logic [TNUM-1:0]   tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    // Clear takes priority so a refill racing a flush never becomes visible.
    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[index]  <= wr_tag;
            data_q[index] <= wr_line;
        end
    end

    assign valid = valid_q[index];
    assign tag   = tag_q[index];
    assign line  = data_q[index];

endmodule

`default_nettype wire

// File: rtl/l1_i_top.sv
// ============================================================================
// l1_i_top: 2-way set-associative read-only L1 instruction cache with L2 refill. Rev 1.0
// ============================================================================
`default_nettype none

module l1_i_top
    import l1_i_pkg::*;
#(
    parameter int TNUM   = 21,
    parameter int INUM   = 26 - TNUM,
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 26 - TNUM_2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [TNUM-1:0]   tag_C_L1,
    input  logic [INUM-1:0]   index_C_L1,
    input  logic [OFF_W-1:0]  offset,
    input  logic              read_C_L1,
    input  logic              flush,
    output logic              stall,
    output logic [WORD_W-1:0] read_data_L1_C,
    output logic              read_L1_L2,
    output logic [INUM_2-1:0] index_L1_L2,
    output logic [TNUM_2-1:0] tag_L1_L2,
    input  logic              ready_L2_L1,
    input  logic [LINE_W-1:0] read_data_L2_L1
);

    localparam int SETS = num_sets(INUM);

    state_t            state;
    state_t            next_state;
    logic [SETS-1:0]   lru;
    logic [NWAYS-1:0]  way_valid;
    logic [NWAYS-1:0]  way_hit;
    logic [NWAYS-1:0]  way_we;
    logic [TNUM-1:0]   way_tag  [NWAYS];
    logic [LINE_W-1:0] way_line [NWAYS];
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              refill_we;
    logic              touch;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word;
    logic              unused_offset_bits;

    generate
        for (genvar w = 0; w < NWAYS; w++) begin : g_way
            l1_i_way_array #(
                .TNUM (TNUM),
                .INUM (INUM)
            ) u_way (
                .clk     (clk),
                .nrst    (nrst),
                .clear   (flush),
                .index   (index_C_L1),
                .we      (way_we[w]),
                .wr_tag  (tag_C_L1),
                .wr_line (read_data_L2_L1),
                .valid   (way_valid[w]),
                .tag     (way_tag[w]),
                .line    (way_line[w])
            );
            assign way_hit[w] = way_valid[w] && (way_tag[w] == tag_C_L1);
            assign way_we[w]  = refill_we && (victim == 1'(w));
        end
    endgenerate

    assign hit      = |way_hit;
    assign hit_way  = ~way_hit[0];
    // Fill an empty way first (way0 before way1); only then consult LRU.
    assign victim   = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru[index_C_L1];
    assign hit_line = way_line[hit_way];
    assign hit_word = hit_line[{offset[OFF_W-1:2], 5'd0} +: WORD_W];

    // The block address is simply re-split into the L2's tag/index widths.
    assign {tag_L1_L2, index_L1_L2} = {tag_C_L1, index_C_L1};
    assign unused_offset_bits       = ^offset[1:0];

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            state <= IDLE;
            lru   <= '0;
        end else begin
            state <= next_state;
            if (refill_we) begin
                lru[index_C_L1] <= ~victim;
            end else if (touch) begin
                lru[index_C_L1] <= ~hit_way;
            end
        end
    end

    always_comb begin
        next_state     = state;
        stall          = 1'b0;
        read_L1_L2     = 1'b0;
        read_data_L1_C = '0;
        refill_we      = 1'b0;
        touch          = 1'b0;
        case (state)
            IDLE: begin
                if (read_C_L1) begin
                    if (hit) begin
                        read_data_L1_C = hit_word;
                        touch          = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        next_state = MISS;
                    end
                end
            end
            MISS: begin
                stall      = 1'b1;
                read_L1_L2 = 1'b1;
                if (ready_L2_L1) begin
                    refill_we  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_l1_i_top.sv
// ============================================================================
// tb_l1_i_top: scoreboard bench with an LRU cache model and an L2 memory model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_l1_i_top;

    logic         clk = 1'b0;
    logic         nrst;
    logic [20:0]  tag_C_L1;
    logic [4:0]   index_C_L1;
    logic [5:0]   offset;
    logic         read_C_L1;
    logic         flush;
    logic         stall;
    logic [31:0]  read_data_L1_C;
    logic         read_L1_L2;
    logic [7:0]   index_L1_L2;
    logic [17:0]  tag_L1_L2;
    logic         ready_L2_L1;
    logic [511:0] read_data_L2_L1;

    l1_i_top dut (
        .clk             (clk),
        .nrst            (nrst),
        .tag_C_L1        (tag_C_L1),
        .index_C_L1      (index_C_L1),
        .offset          (offset),
        .read_C_L1       (read_C_L1),
        .flush           (flush),
        .stall           (stall),
        .read_data_L1_C  (read_data_L1_C),
        .read_L1_L2      (read_L1_L2),
        .index_L1_L2     (index_L1_L2),
        .tag_L1_L2       (tag_L1_L2),
        .ready_L2_L1     (ready_L2_L1),
        .read_data_L2_L1 (read_data_L2_L1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [25:0] blk;
        int          stall_cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          tmo_cnt = 0;
    int          tmo_seen = 0;
    bit          mon_skip = 1'b0;
    bit          done = 1'b0;
    logic [20:0] mt [32][2];
    int          mn [32];

    // L2 contents: a fixed function of block address and word number.
    function automatic logic [31:0] mem_word(input logic [25:0] blk, input int w);
        return (32'(blk) * 32'h9E37_79B1) ^ (32'(w) * 32'h0101_0101) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [511:0] mem_line(input logic [25:0] blk);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = mem_word(blk, w);
        return l;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    // Per-set true-LRU model: slot 0 is least recent, slot 1 most recent.
    function automatic bit model_probe(input logic [20:0] t, input logic [4:0] i);
        return (mn[i] >= 1 && mt[i][0] == t) || (mn[i] == 2 && mt[i][1] == t);
    endfunction

    function automatic bit model_access(input logic [20:0] t, input logic [4:0] i);
        if (mn[i] == 2 && mt[i][1] == t) return 1'b0;
        if (mn[i] >= 1 && mt[i][0] == t) begin
            if (mn[i] == 2) begin
                mt[i][0] = mt[i][1];
                mt[i][1] = t;
            end
            return 1'b0;
        end
        if (mn[i] < 2) begin
            mt[i][mn[i]] = t;
            mn[i]++;
        end else begin
            mt[i][0] = mt[i][1];
            mt[i][1] = t;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mn[i] = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic do_read(input logic [20:0] t, input logic [4:0] i, input logic [5:0] o,
                           input int lat, input bit fl);
        exp_t e;
        int   waited;
        int   guard;
        bit   miss;
        miss           = model_access(t, i);
        e.data         = mem_word({t, i}, int'(o[5:2]));
        e.blk          = {t, i};
        e.stall_cycles = miss ? lat + 2 : 0;
        exp_q.push_back(e);
        tag_C_L1   = t;
        index_C_L1 = i;
        offset     = o;
        read_C_L1  = 1'b1;
        flush      = fl;
        waited     = 0;
        guard      = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            if (read_L1_L2) begin
                if (waited >= lat) begin
                    ready_L2_L1     = 1'b1;
                    read_data_L2_L1 = mem_line({t, i});
                end else begin
                    waited++;
                end
            end
            guard++;
            if (guard > 100) begin
                tmo_cnt++;
                break;
            end
            @(posedge clk); #1;
            ready_L2_L1 = 1'b0;
            flush       = 1'b0;
        end
        @(posedge clk); #1;
        read_C_L1   = 1'b0;
        flush       = 1'b0;
        ready_L2_L1 = 1'b0;
        if (fl) model_clear();
    endtask

    task automatic idle(input int n, input bit junk_ready);
        repeat (n) begin
            if (junk_ready) begin
                ready_L2_L1     = 1'b1;
                read_data_L2_L1 = rand_line();
            end
            @(posedge clk); #1;
            ready_L2_L1 = 1'b0;
        end
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
    endtask

    // Start a miss, sit in the refill wait, then kill it with flush or reset.
    task automatic abort_miss(input logic [20:0] t, input logic [4:0] i, input int wait_n,
                              input bit use_reset);
        mon_skip   = 1'b1;
        tag_C_L1   = t;
        index_C_L1 = i;
        offset     = 6'd0;
        read_C_L1  = 1'b1;
        repeat (wait_n + 1) @(posedge clk);
        #1;
        if (use_reset) nrst = 1'b0;
        else flush = 1'b1;
        @(posedge clk); #1;
        nrst      = 1'b1;
        flush     = 1'b0;
        read_C_L1 = 1'b0;
        mon_skip  = 1'b0;
        model_clear();
    endtask

    initial begin : monitor
        int   scnt;
        bit   fin;
        exp_t e;
        scnt = 0;
        fin  = 1'b0;
        forever begin
            @(negedge clk);
            if (tmo_cnt != tmo_seen) begin
                chk("l2_timeout", 64'(tmo_cnt), 64'(tmo_seen));
                tmo_seen = tmo_cnt;
            end
            if (!nrst || mon_skip) begin
                scnt = 0;
            end else if (read_C_L1) begin
                if (stall) begin
                    if (scnt > 0 && exp_q.size() > 0)
                        chk("l2_req", 64'({read_L1_L2, tag_L1_L2, index_L1_L2}),
                            64'({1'b1, exp_q[0].blk}));
                    scnt++;
                end else if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data", 64'(read_data_L1_C), 64'(e.data));
                    chk("stall_cycles", 64'(scnt), 64'(e.stall_cycles));
                    scnt = 0;
                end
            end else begin
                chk("idle_outputs", 64'({stall, read_L1_L2, read_data_L1_C}), 64'd0);
            end
            if (done && !fin) begin
                chk("sb_empty", 64'(exp_q.size()), 64'd0);
                fin = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [20:0] t;
        logic [4:0]  i;
        logic [5:0]  o;
        int          r;
        nrst            = 1'b0;
        tag_C_L1        = '0;
        index_C_L1      = '0;
        offset          = '0;
        read_C_L1       = 1'b0;
        flush           = 1'b0;
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(2, 1'b0);

        do_read(21'd0, 5'd1, 6'h00, 0, 1'b0);   // cold fill way0
        do_read(21'd1, 5'd1, 6'h00, 1, 1'b0);   // fill way1
        do_read(21'd0, 5'd1, 6'h3C, 0, 1'b0);   // hit, last word
        do_read(21'd1, 5'd1, 6'h08, 0, 1'b0);   // hit, word2
        do_read(21'd0, 5'd1, 6'h00, 0, 1'b0);
        do_read(21'd1, 5'd1, 6'h00, 0, 1'b0);
        do_read(21'd2, 5'd1, 6'h10, 2, 1'b0);   // evicts tag 0
        do_read(21'd1, 5'd1, 6'h04, 0, 1'b0);
        do_read(21'd0, 5'd1, 6'h00, 12, 1'b0);  // long L2 latency
        flush_pulse();
        do_read(21'd0, 5'd1, 6'h00, 0, 1'b0);
        do_read(21'd0, 5'd1, 6'h04, 0, 1'b1);   // hit with flush in the same cycle
        do_read(21'd0, 5'd1, 6'h04, 0, 1'b0);
        abort_miss(21'd5, 5'd3, 3, 1'b0);
        idle(2, 1'b1);
        do_read(21'd5, 5'd3, 6'h00, 0, 1'b0);
        abort_miss(21'd7, 5'd2, 4, 1'b1);
        idle(1, 1'b0);
        do_read(21'd7, 5'd2, 6'h00, 0, 1'b0);
        do_read(21'd5, 5'd3, 6'h00, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            t = 21'($urandom_range(0, 3));
            i = 5'($urandom_range(0, 3));
            o = 6'($urandom_range(0, 63));
            if (r == 0) flush_pulse();
            else if (r == 1) idle(1, 1'b1);
            else if (r == 2 && model_probe(t, i)) do_read(t, i, o, 0, 1'b1);
            else do_read(t, i, o, int'($urandom_range(0, 4)), 1'b0);
        end

        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
